rot_filter: RTL and testbench

ROT_FILTER -- requirements
Module: rot_filter

---
 rtl/rot_filter.sv | 131 +++++++++++++
 tb/tb_rot_filter.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/rot_filter.sv
// Two-channel rotary encoder front end: synchronize and debounce A/B, then
// emit registered edge pulses and a sticky illegal-step flag once settled.

module rot_chan #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned CNT_W           = 16
) (
  input  logic clk,
  input  logic nrst,
  input  logic raw_i,
  output logic filt_o,
  output logic upd_o,
  output logic idle_o
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             filt_q, filt_d;
  logic             diff;

  assign diff   = sync_q[1] ^ filt_q;
  assign filt_o = filt_q;
  assign idle_o = !diff && (cnt_q == '0);

  // Counter saturates at LAST by construction: reaching it while still
  // differing commits the new level and clears the count.
  always_comb begin
    cnt_d  = '0;
    filt_d = filt_q;
    upd_o  = 1'b0;
    if (diff) begin
      if (cnt_q == LAST) begin
        filt_d = sync_q[1];
        upd_o  = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (nrst) begin
      sync_q <= '0;
      cnt_q  <= '0;
      filt_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], raw_i};
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end
endmodule

module rot_filter #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned CNT_W           = 16
) (
  input  logic clk,
  input  logic nrst,
  input  logic rotA,
  input  logic rotB,
  input  logic err_clr,
  output logic enc_a,
  output logic enc_b,
  output logic a_edge,
  output logic b_edge,
  output logic rdy,
  output logic err
);
  localparam int NUM_LANES   = 2;
  localparam int SYNC_STAGES = 2;

  typedef enum logic {SETTLE, RUN} state_t;

  logic [NUM_LANES-1:0]   raw, filt, upd, idle;
  logic [NUM_LANES-1:0]   edge_q, edge_d;
  logic [SYNC_STAGES-1:0] vld_pipe_q;
  state_t                 state_q, state_d;
  logic                   err_q, err_d;

  assign raw = {rotB, rotA};

  rot_chan #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_chan [NUM_LANES-1:0] (
    .clk   (clk),
    .nrst  (nrst),
    .raw_i (raw),
    .filt_o(filt),
    .upd_o (upd),
    .idle_o(idle)
  );

  // The settle check waits until the synchronizers hold real pin samples,
  // otherwise the all-zero reset image would look settled on the first edge.
  always_comb begin
    state_d = state_q;
    if (state_q == SETTLE && vld_pipe_q[SYNC_STAGES-1] && (&idle))
      state_d = RUN;
  end

  always_comb begin
    edge_d = (state_q == RUN) ? upd : '0;
    err_d  = err_q;
    if (state_q == RUN && (&upd)) err_d = 1'b1;
    else if (err_clr)             err_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (nrst) begin
      vld_pipe_q <= '0;
      state_q    <= SETTLE;
      edge_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      vld_pipe_q <= {vld_pipe_q[SYNC_STAGES-2:0], 1'b1};
      state_q    <= state_d;
      edge_q     <= edge_d;
      err_q      <= err_d;
    end
  end

  assign enc_a  = filt[0];
  assign enc_b  = filt[1];
  assign a_edge = edge_q[0];
  assign b_edge = edge_q[1];
  assign err    = err_q;
  assign rdy    = (state_q == RUN);
endmodule

// File: tb/tb_rot_filter.sv
// Scoreboard bench for rot_filter with DEBOUNCE_CYCLES=4: expected output
// snapshots are queued with their edge number, a monitor pops and compares.

module tb_rot_filter;
  localparam int DC = 4;
  localparam int CW = 3;

  logic clk = 1'b0, nrst = 1'b1, rotA = 1'b0, rotB = 1'b0, err_clr = 1'b0;
  logic enc_a, enc_b, a_edge, b_edge, rdy, err;

  int checks = 0, errors = 0, cyc = 0;

  // snapshot order: {enc_a, enc_b, a_edge, b_edge, err, rdy}
  typedef struct {
    int         c;
    logic [5:0] v;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  rot_filter #(.DEBOUNCE_CYCLES(DC), .CNT_W(CW)) dut (
    .clk    (clk),
    .nrst   (nrst),
    .rotA   (rotA),
    .rotB   (rotB),
    .err_clr(err_clr),
    .enc_a  (enc_a),
    .enc_b  (enc_b),
    .a_edge (a_edge),
    .b_edge (b_edge),
    .rdy    (rdy),
    .err    (err)
  );

  task automatic expect_at(input int c, input logic [5:0] v);
    exp_t e;
    e.c = c;
    e.v = v;
    sb.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: any output change must be announced by the scoreboard head.
  initial begin
    logic [5:0] snap, prev;
    exp_t e;
    prev = '0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      snap = {enc_a, enc_b, a_edge, b_edge, err, rdy};
      while (sb.size() > 0 && sb[0].c < cyc) begin
        e = sb.pop_front();
        checks++; errors++;
        $display("FAIL missed edge=%0d expected=%b", e.c, e.v);
      end
      if (sb.size() > 0 && sb[0].c == cyc) begin
        e = sb.pop_front();
        checks++;
        if (snap !== e.v) begin
          errors++;
          $display("FAIL snapshot edge=%0d actual=%b expected=%b", cyc, snap, e.v);
        end
      end else if (snap !== prev) begin
        checks++; errors++;
        $display("FAIL unexpected_change edge=%0d actual=%b previous=%b", cyc, snap, prev);
      end
      prev = snap;
    end
  end

  initial begin
    int k, k2, r;
    exp_t e;

    // reset with pins low, then settle
    expect_at(2, 6'b000000);
    step(3);
    nrst = 1'b0;
    r = cyc;
    expect_at(r + 2, 6'b000000);
    expect_at(r + 3, 6'b000001);
    step(4);

    // clean A rise and fall
    rotA = 1'b1; k = cyc + 1;
    expect_at(k + 4, 6'b000001);
    expect_at(k + 5, 6'b101001);
    expect_at(k + 6, 6'b100001);
    step(8);
    rotA = 1'b0; k = cyc + 1;
    expect_at(k + 5, 6'b001001);
    expect_at(k + 6, 6'b000001);
    step(8);

    // short A glitches must be filtered out entirely
    repeat (10) begin
      rotA = 1'b1; step(3);
      rotA = 1'b0; step(1);
    end
    step(8);
    expect_at(cyc + 1, 6'b000001);
    step(2);

    // clean B rise and fall
    rotB = 1'b1; k = cyc + 1;
    expect_at(k + 5, 6'b010101);
    expect_at(k + 6, 6'b010001);
    step(8);
    rotB = 1'b0; k = cyc + 1;
    expect_at(k + 5, 6'b000101);
    expect_at(k + 6, 6'b000001);
    step(8);

    // both channels together: illegal step, sticky err, then clear
    rotA = 1'b1; rotB = 1'b1; k = cyc + 1;
    expect_at(k + 5, 6'b111111);
    expect_at(k + 6, 6'b110011);
    expect_at(k + 8, 6'b110011);
    expect_at(k + 9, 6'b110001);
    step(9);
    err_clr = 1'b1; step(1);
    err_clr = 1'b0;

    // set coincides with clear: set wins
    rotA = 1'b0; rotB = 1'b0; k2 = cyc + 1;
    expect_at(k2 + 5, 6'b001111);
    expect_at(k2 + 6, 6'b000011);
    expect_at(k2 + 7, 6'b000001);
    step(4);
    err_clr = 1'b1; step(2);
    err_clr = 1'b0; step(1);
    err_clr = 1'b1; step(1);
    err_clr = 1'b0; step(4);

    // reset mid-count on A, then pins high through the debounce path
    rotA = 1'b1; k = cyc + 1;
    step(4);
    nrst = 1'b1; rotB = 1'b1;
    expect_at(k + 4, 6'b000000);
    step(1);
    nrst = 1'b0;
    r = k + 5;
    expect_at(r + 4, 6'b000000);
    expect_at(r + 5, 6'b110000);
    expect_at(r + 6, 6'b110001);
    step(12);

    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++; errors++;
      $display("FAIL leftover edge=%0d expected=%b", e.c, e.v);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
